ball_motion_scheduler: RTL and testbench

- Clocked motion controller for the metaball renderer. It owns the position and velocity state of NUM_BALLS balls.
- Once per frame, on the v_sync falling edge, it steps every ball through a single shared adder, one ball at a time.
- New positions are published to the renderer all at once, so all balls move on the same frame.
- Replaces per-ball logic clocked directly from v_sync; everything runs on clk_50mhz.

---
 rtl/ball_motion_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_ball_motion_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_scheduler.sv
// ============================================================================
//  Module      : ball_motion_scheduler
//  Description : Per-frame position/velocity sequencer for the metaball
//                renderer. On each v_sync falling edge every ball is stepped
//                through one shared position adder and one shared velocity
//                adder, one axis per cycle. The results are then published to
//                the renderer in a single cycle, so all balls move together.
//                Optional build macro BALL_SCHED_VLIMIT_EN saturates the
//                velocities to [-VMAX, +VMAX].
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ball_motion_scheduler #(
    parameter int NUM_BALLS     = 2,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_SIZE     = 128,
    parameter int VMAX          = 64
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    v_sync,
    input  logic                    freeze,
    output logic [10*NUM_BALLS-1:0] ball_x,
    output logic [10*NUM_BALLS-1:0] ball_y,
    output logic                    busy,
    output logic [7:0]              frame_count,
    output logic                    overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BALLS - 1);

    // Velocity steers toward the centre of the travel range on each axis.
    localparam logic [9:0] c_X_MID = 10'((SCREEN_WIDTH  - BALL_SIZE) / 2);
    localparam logic [9:0] c_Y_MID = 10'((SCREEN_HEIGHT - BALL_SIZE) / 2);

    localparam logic [9:0] c_VEL_INC = 10'd1;
    localparam logic [9:0] c_VEL_DEC = 10'h3FF;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_STEP_X  = 2'd1;
    localparam logic [1:0] c_STEP_Y  = 2'd2;
    localparam logic [1:0] c_PUBLISH = 2'd3;

    // Balls start spread evenly along a diagonal of the travel range.
    function automatic logic [9:0] init_x(input int i);
        return 10'((SCREEN_WIDTH - BALL_SIZE) * (i + 1) / (NUM_BALLS + 1));
    endfunction

    function automatic logic [9:0] init_y(input int i);
        return 10'((SCREEN_HEIGHT - BALL_SIZE) * (NUM_BALLS - i) / (NUM_BALLS + 1));
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_v_sync_q;
    logic               w_start;
    logic               w_launch;
    logic               w_step_x;
    logic               w_step_y;
    logic               w_publish;
    logic [c_IDX_W-1:0] r_idx;

    logic [9:0]         r_x  [NUM_BALLS];
    logic [9:0]         r_y  [NUM_BALLS];
    logic [9:0]         r_vx [NUM_BALLS];
    logic [9:0]         r_vy [NUM_BALLS];

    logic [9:0]         w_pos;
    logic [9:0]         w_vel;
    logic [9:0]         w_mid;
    logic [9:0]         w_pos_next;
    logic [9:0]         w_vel_sum;
    logic [9:0]         w_vel_next;

    // Falling edge of v_sync, gated by freeze, launches a frame update.
    assign w_start  = r_v_sync_q & ~v_sync & ~freeze;
    assign w_launch = w_start & (r_state == c_IDLE);

    // Register v_sync for falling-edge detection.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_v_sync_q <= 1'b1;
        end else begin
            r_v_sync_q <= v_sync;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: X then Y for each ball, then a single publish cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_next_state = c_STEP_X;
                end
            end
            c_STEP_X: begin
                w_next_state = c_STEP_Y;
            end
            c_STEP_Y: begin
                if (r_idx == c_LAST_IDX) begin
                    w_next_state = c_PUBLISH;
                end else begin
                    w_next_state = c_STEP_X;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // State-decoded control strobes and the busy flag.
    always_comb begin
        busy      = (r_state != c_IDLE);
        w_step_x  = (r_state == c_STEP_X);
        w_step_y  = (r_state == c_STEP_Y);
        w_publish = (r_state == c_PUBLISH);
    end

    // Ball index: cleared on launch, advanced after each ball's Y step.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_launch) begin
            r_idx <= '0;
        end else if (w_step_y && (r_idx != c_LAST_IDX)) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Shared arithmetic
    // ------------------------------------------------------------------------

    // Operand mux plus the single position adder and single velocity adder.
    // Position moves by velocity/4 (arithmetic shift, rounds toward -inf).
    always_comb begin
        w_pos      = w_step_y ? r_y[r_idx]  : r_x[r_idx];
        w_vel      = w_step_y ? r_vy[r_idx] : r_vx[r_idx];
        w_mid      = w_step_y ? c_Y_MID     : c_X_MID;
        w_pos_next = w_pos + {w_vel[9], w_vel[9], w_vel[9:2]};
        w_vel_sum  = w_vel + ((w_pos_next < w_mid) ? c_VEL_INC : c_VEL_DEC);
    end

`ifdef BALL_SCHED_VLIMIT_EN
    localparam logic [9:0] c_VEL_POS = 10'(VMAX);
    localparam logic [9:0] c_VEL_NEG = 10'(-VMAX);

    // Clamp the updated velocity to [-VMAX, +VMAX].
    always_comb begin
        w_vel_next = w_vel_sum;
        if ($signed(w_vel_sum) > $signed(c_VEL_POS)) begin
            w_vel_next = c_VEL_POS;
        end else if ($signed(w_vel_sum) < $signed(c_VEL_NEG)) begin
            w_vel_next = c_VEL_NEG;
        end
    end
`else
    logic w_unused_vmax;
    assign w_unused_vmax = (VMAX == 0);

    // Velocity wraps freely modulo 1024.
    always_comb begin
        w_vel_next = w_vel_sum;
    end
`endif

    // ------------------------------------------------------------------------
    // Working state
    // ------------------------------------------------------------------------

    // Working positions and velocities, written back one axis per cycle.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_x[i]  <= init_x(i);
                r_y[i]  <= init_y(i);
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
        end else if (w_step_x) begin
            r_x[r_idx]  <= w_pos_next;
            r_vx[r_idx] <= w_vel_next;
        end else if (w_step_y) begin
            r_y[r_idx]  <= w_pos_next;
            r_vy[r_idx] <= w_vel_next;
        end
    end

    // Published positions: copied from the working set in one cycle so the
    // renderer never sees a half-updated frame.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                ball_x[10*i +: 10] <= init_x(i);
                ball_y[10*i +: 10] <= init_y(i);
            end
        end else if (w_publish) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                ball_x[10*i +: 10] <= r_x[i];
                ball_y[10*i +: 10] <= r_y[i];
            end
        end
    end

    // Completed-frame counter and sticky overrun flag.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            if (w_publish) begin
                frame_count <= frame_count + 8'd1;
            end
            if (w_start && (r_state != c_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ball_motion_scheduler.sv
// ============================================================================
//  Module      : tb_ball_motion_scheduler
//  Description : Directed self-checking bench for ball_motion_scheduler with
//                default geometry (two balls). Expected positions are worked
//                out by hand from the stepping rules. Build with
//                BALL_SCHED_VLIMIT_EN to check the VMAX=3 saturation case.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ball_motion_scheduler;

`ifdef BALL_SCHED_VLIMIT_EN
    localparam int c_VMAX = 3;
`else
    localparam int c_VMAX = 64;
`endif

    logic        clk_50mhz;
    logic        reset;
    logic        v_sync;
    logic        freeze;
    logic [19:0] ball_x;
    logic [19:0] ball_y;
    logic        busy;
    logic [7:0]  frame_count;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    ball_motion_scheduler #(
        .NUM_BALLS     (2),
        .SCREEN_WIDTH  (800),
        .SCREEN_HEIGHT (600),
        .BALL_SIZE     (128),
        .VMAX          (c_VMAX)
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .v_sync      (v_sync),
        .freeze      (freeze),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .busy        (busy),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    function automatic logic [19:0] pk(input int b1, input int b0);
        return {10'(b1), 10'(b0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Drive one v_sync falling edge and watch for `window` cycles. Counts
    // busy cycles and flags any published-output change while busy.
    task automatic run_frame(input logic [19:0] old_x, input logic [19:0] old_y,
                             input bit glitch, input bit freeze_mid, input int window,
                             output int busy_cycles, output bit stable);
        @(negedge clk_50mhz);
        v_sync = 1'b0;
        busy_cycles = 0;
        stable = 1'b1;
        for (int c = 0; c < window; c++) begin
            @(negedge clk_50mhz);
            if (busy) begin
                busy_cycles++;
                if ((ball_x !== old_x) || (ball_y !== old_y)) stable = 1'b0;
            end
            if (glitch && c == 0) v_sync = 1'b1;
            if (glitch && c == 1) v_sync = 1'b0;
            if (freeze_mid && c == 1) freeze = 1'b1;
            if (freeze_mid && c == 8) freeze = 1'b0;
        end
        v_sync = 1'b1;
        @(negedge clk_50mhz);
    endtask

    initial begin
        int  bc;
        bit  st;
        logic [19:0] ex5, ey5, ex6, ey6, ex7, ey7;

`ifdef BALL_SCHED_VLIMIT_EN
        ex5 = pk(444, 224); ey5 = pk(157, 310);
        ex6 = pk(443, 224); ey6 = pk(157, 309);
        ex7 = pk(442, 224); ey7 = pk(157, 308);
`else
        ex5 = pk(444, 225); ey5 = pk(158, 310);
        ex6 = pk(442, 226); ey6 = pk(159, 308);
        ex7 = pk(440, 227); ey7 = pk(160, 306);
`endif

        // Reset state
        reset  = 1'b1;
        v_sync = 1'b1;
        freeze = 1'b0;
        repeat (2) @(negedge clk_50mhz);
        check("rst_x",   32'(ball_x),      32'(pk(448, 224)));
        check("rst_y",   32'(ball_y),      32'(pk(157, 314)));
        check("rst_busy", 32'(busy),       32'd0);
        check("rst_fc",  32'(frame_count), 32'd0);
        check("rst_ovr", 32'(overrun),     32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_50mhz);

        // Frame 1: velocities were zero, so positions are unchanged
        run_frame(pk(448, 224), pk(157, 314), 1'b0, 1'b0, 12, bc, st);
        check("f1_busy", 32'(bc), 32'd5);
        check("f1_stable", 32'(st), 32'd1);
        check("f1_x", 32'(ball_x), 32'(pk(448, 224)));
        check("f1_y", 32'(ball_y), 32'(pk(157, 314)));
        check("f1_fc", 32'(frame_count), 32'd1);

        // Frames 2..5
        run_frame(pk(448, 224), pk(157, 314), 1'b0, 1'b0, 12, bc, st);
        check("f2_stable", 32'(st), 32'd1);
        check("f2_x", 32'(ball_x), 32'(pk(447, 224)));
        check("f2_y", 32'(ball_y), 32'(pk(157, 313)));
        run_frame(pk(447, 224), pk(157, 313), 1'b0, 1'b0, 12, bc, st);
        check("f3_x", 32'(ball_x), 32'(pk(446, 224)));
        check("f3_y", 32'(ball_y), 32'(pk(157, 312)));
        run_frame(pk(446, 224), pk(157, 312), 1'b0, 1'b0, 12, bc, st);
        check("f4_x", 32'(ball_x), 32'(pk(445, 224)));
        check("f4_y", 32'(ball_y), 32'(pk(157, 311)));
        run_frame(pk(445, 224), pk(157, 311), 1'b0, 1'b0, 12, bc, st);
        check("f5_stable", 32'(st), 32'd1);
        check("f5_x", 32'(ball_x), 32'(ex5));
        check("f5_y", 32'(ball_y), 32'(ey5));
        check("f5_fc", 32'(frame_count), 32'd5);
        check("f5_ovr", 32'(overrun), 32'd0);

        // Frame 6 with a second falling edge two cycles into the sequence
        run_frame(ex5, ey5, 1'b1, 1'b0, 14, bc, st);
        check("ovr_busy", 32'(bc), 32'd5);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_fc", 32'(frame_count), 32'd6);
        check("f6_x", 32'(ball_x), 32'(ex6));
        check("f6_y", 32'(ball_y), 32'(ey6));

        // Freeze across three edges
        freeze = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(ex6, ey6, 1'b0, 1'b0, 10, bc, st);
            check("frz_busy", 32'(bc), 32'd0);
        end
        check("frz_fc", 32'(frame_count), 32'd6);
        check("frz_x", 32'(ball_x), 32'(ex6));
        check("frz_y", 32'(ball_y), 32'(ey6));
        check("frz_ovr", 32'(overrun), 32'd1);
        freeze = 1'b0;

        // Resume: frame 7
        run_frame(ex6, ey6, 1'b0, 1'b0, 12, bc, st);
        check("f7_busy", 32'(bc), 32'd5);
        check("f7_x", 32'(ball_x), 32'(ex7));
        check("f7_y", 32'(ball_y), 32'(ey7));
        check("f7_fc", 32'(frame_count), 32'd7);

        // Frame 8: v_sync held low 20 cycles, freeze pulsed mid-sequence
        run_frame(ex7, ey7, 1'b0, 1'b1, 20, bc, st);
        check("hold_busy", 32'(bc), 32'd5);
        check("hold_fc", 32'(frame_count), 32'd8);

        // Reset asserted mid-sequence
        @(negedge clk_50mhz);
        v_sync = 1'b0;
        repeat (2) @(negedge clk_50mhz);
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        @(negedge clk_50mhz);
        check("mid_x",  32'(ball_x),      32'(pk(448, 224)));
        check("mid_y",  32'(ball_y),      32'(pk(157, 314)));
        check("mid_fc", 32'(frame_count), 32'd0);
        check("mid_ovr", 32'(overrun),    32'd0);
        v_sync = 1'b1;
        @(negedge clk_50mhz);
        reset = 1'b0;
        repeat (6) @(negedge clk_50mhz);
        check("post_busy", 32'(busy), 32'd0);
        check("post_x", 32'(ball_x), 32'(pk(448, 224)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
